ct_spsram_256x52_acc_ctrl: RTL and testbench
============================================

CT_SPSRAM_256X52_ACC_CTRL -- requirements
Module: ct_spsram_256x52_acc_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: forever_cpuclk is the only clock; cpurst_b is synchronous and active-low.
REQ-002 SHALL provide these ports (name, direction, width, meaning):
- forever_cpuclk  in  1  clock.
- cpurst_b  in  1  synchronous active-low reset.
- wr_req_vld  in  1  write request.
- wr_req_rdy  out  1  write accepted this cycle.
- wr_req_idx  in  8  write row.
- wr_req_data  in  52  write data.
- wr_req_bmask  in  2  half enables; bit0 = [25:0], bit1 = [51:26].
- rd_req_vld  in  1  read request.
- rd_req_rdy  out  1  read accepted this cycle.
- rd_req_idx  in  8  read row.
- rd_resp_vld  out  1  read data valid, one-cycle pulse, no backpressure.
- rd_resp_data  out  52  read data.
- init_done  out  1  array ready for traffic.
- sram_a  out  8  SRAM address.
- sram_cen  out  1  SRAM chip enable, active low.
- sram_gwen  out  1  SRAM global write enable, active low.
- sram_wen  out  52  SRAM bit write enables, active low.
- sram_d  out  52  SRAM write data.
- sram_q  in  52  SRAM read data, valid the cycle after a read is issued.

Function
REQ-003 SHALL use the FSM states INIT and RUN; reset SHALL enter INIT (macro defined) or RUN (macro undefined).
REQ-004 In INIT, SHALL write zero to rows 0..255 at one row per cycle, with sram_cen=0, sram_gwen=0 and sram_wen all 0, and hold both rdy outputs at 0.
REQ-005 After row 255 is written, SHALL assert init_done and enter RUN on the next cycle; init_done SHALL stay at 1 until reset.
REQ-006 In RUN, a request is granted when its vld is 1 and its rdy is 1; rdy SHALL be combinational from the arbiter, and at most one request SHALL be granted per cycle.
REQ-007 Arbitration SHALL give reads fixed priority, except that a 2-bit starvation counter counts consecutive cycles in which a write is blocked by a read; at a count of 3, the write SHALL win the next cycle and the counter SHALL clear.
REQ-008 The starvation counter SHALL clear on every write grant and on every cycle with wr_req_vld=0.
REQ-009 A read grant SHALL drive sram_cen=0, sram_gwen=1 and sram_a=rd_req_idx.
REQ-010 A write grant SHALL drive sram_cen=0, sram_gwen=0, sram_a=wr_req_idx and sram_d=wr_req_data; sram_wen[25:0] SHALL equal ~bmask[0] replicated and sram_wen[51:26] SHALL equal ~bmask[1] replicated.
REQ-011 A write with bmask=00 SHALL still be granted and consume the cycle; the array SHALL be left unchanged.
REQ-012 With no grant, SHALL drive sram_cen=1 and sram_gwen=1, and sram_a SHALL hold its last value.
REQ-013 Read latency: for a read granted in cycle T, SHALL capture sram_q at the end of T+1 and present rd_resp_vld=1 with rd_resp_data in T+2 only.
REQ-014 rd_resp_data SHALL hold its value while rd_resp_vld=0.
REQ-015 Same-index read and write in the same cycle: the read wins and SHALL return the old data; the write follows in a later cycle.
REQ-016 A write in cycle T followed by a read of the same index in T+1 SHALL return the new data.
REQ-017 Back-to-back reads SHALL sustain one per cycle with in-order responses.

Reset
REQ-018 While cpurst_b=0, SHALL force: rd_resp_vld=0, rd_resp_data=0, init_done=0, both rdy=0, sram_cen=1, sram_gwen=1, sram_wen all 1, sram_a=0, sram_d=0, starvation counter 0, init counter 0.
REQ-019 Reset asserted mid-operation SHALL discard in-flight read responses; with the macro defined, INIT SHALL restart from row 0.

Configuration
REQ-020 Macro CT_SPSRAM_ACC_INIT_EN: when defined, SHALL provide the INIT sweep described in REQ-004 and REQ-005.
REQ-021 When CT_SPSRAM_ACC_INIT_EN is undefined, SHALL start in RUN, set init_done=1 on the first cycle after reset release, and leave array contents undefined.

Structure
REQ-022 Package ct_spsram_acc_pkg SHALL hold the constants IDX_W=8, DATA_W=52, HALF_W=26, STARVE_MAX=3 and the FSM state typedef.
REQ-023 The only sub-module SHALL be ct_spsram_256x52_init_seq, which contains the INIT counter and done flag; the SRAM array SHALL be instantiated by the parent, not inside this block.

Verification
REQ-024 Reset release with the macro defined -> 256 consecutive zero writes to rows 0..255, then init_done=1 in cycle 257.
REQ-025 Write idx 0x12, data 0xABCDE_1234567, bmask 11; next cycle read idx 0x12 -> rd_resp_vld two cycles after the read grant with data 0xABCDE_1234567.
REQ-026 Write idx 0x05 with all-ones data and bmask 01 after init -> a read of idx 0x05 returns data[25:0] all ones and data[51:26]=0.
REQ-027 rd_req_vld and wr_req_vld held at 1 for 8 cycles -> grant sequence R,R,R,W,R,R,R,W.
REQ-028 Reset asserted in RUN during an outstanding read -> no rd_resp_vld pulse, and INIT restarts at row 0.
REQ-029 Same idx 0x40 read and written in the same cycle (old data 0x1, new data 0x2) -> the read returns 0x1, and a subsequent read returns 0x2.

Source files
------------

// File: rtl/ct_spsram_acc_pkg.sv
// Shared constants, FSM state type and write-enable helper for the
// 256x52 single-port SRAM access controller.
// Optional feature macro used by the controller: CT_SPSRAM_ACC_INIT_EN.
package ct_spsram_acc_pkg;

  localparam int unsigned IDX_W      = 8;
  localparam int unsigned DATA_W     = 52;
  localparam int unsigned HALF_W     = 26;
  localparam int unsigned STARVE_MAX = 3;
  localparam int unsigned STARVE_W   = 2;
  localparam int unsigned ROWS       = 256;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } acc_state_e;

  // Active-low bit write enables from the two half enables.
  function automatic logic [DATA_W-1:0] wen_from_bmask(input logic [1:0] bmask);
    return {{HALF_W{~bmask[1]}}, {HALF_W{~bmask[0]}}};
  endfunction

endpackage

// File: rtl/ct_spsram_256x52_init_seq.sv
// Row counter and done flag for the power-up zero sweep.
// Macro: CT_SPSRAM_ACC_INIT_EN (defined: done after the last row is swept;
// undefined: done on the first cycle after reset release).
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   sweep_en_i    sweep row row_o this cycle
//   row_o         row being swept
//   last_row_c_o  row_o is the final row (combinational)
//   done_o        array ready for traffic (registered)
module ct_spsram_256x52_init_seq
  import ct_spsram_acc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sweep_en_i,
  output logic [IDX_W-1:0] row_o,
  output logic             last_row_c_o,
  output logic             done_o
);

  logic [IDX_W-1:0] row_q, row_d;
  logic             done_q, done_d;

  assign last_row_c_o = (row_q == IDX_W'(ROWS - 1));
  assign row_o        = row_q;
  assign done_o       = done_q;

  // Advance one row per sweep cycle; latch done once the sweep has finished.
  always_comb begin
    row_d  = row_q;
    done_d = done_q;
    if (sweep_en_i) begin
      row_d = row_q + IDX_W'(1);
    end
`ifdef CT_SPSRAM_ACC_INIT_EN
    if (sweep_en_i && last_row_c_o) begin
      done_d = 1'b1;
    end
`else
    done_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_q  <= '0;
      done_q <= 1'b0;
    end else begin
      row_q  <= row_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/ct_spsram_256x52_acc_ctrl.sv
// Access controller for an external 256x52 single-port SRAM: optional zero
// sweep after reset, read-priority arbitration with write starvation relief,
// and a two-cycle registered read response path.
// Macro: CT_SPSRAM_ACC_INIT_EN enables the INIT zero sweep after reset.
// Ports:
//   forever_cpuclk, cpurst_b             clock, synchronous active-low reset
//   wr_req_* / wr_req_rdy                write request channel (rdy combinational)
//   rd_req_* / rd_req_rdy                read request channel (rdy combinational)
//   rd_resp_vld, rd_resp_data            read response, no backpressure
//   init_done                            array ready for traffic
//   sram_a/cen/gwen/wen/d, sram_q        SRAM macro interface
module ct_spsram_256x52_acc_ctrl
  import ct_spsram_acc_pkg::*;
(
  input  logic              forever_cpuclk,
  input  logic              cpurst_b,
  input  logic              wr_req_vld,
  output logic              wr_req_rdy,
  input  logic [IDX_W-1:0]  wr_req_idx,
  input  logic [DATA_W-1:0] wr_req_data,
  input  logic [1:0]        wr_req_bmask,
  input  logic              rd_req_vld,
  output logic              rd_req_rdy,
  input  logic [IDX_W-1:0]  rd_req_idx,
  output logic              rd_resp_vld,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              init_done,
  output logic [IDX_W-1:0]  sram_a,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wen,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

`ifdef CT_SPSRAM_ACC_INIT_EN
  localparam acc_state_e RST_STATE = INIT;
`else
  localparam acc_state_e RST_STATE = RUN;
`endif

  acc_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [IDX_W-1:0]    a_q;
  logic                rd_pend_q;
  logic                rd_resp_vld_q;
  logic [DATA_W-1:0]   rd_resp_data_q;

  logic [IDX_W-1:0]    init_row;
  logic                init_last_c;
  logic                init_done_w;
  logic                in_init;
  logic                grant_en;
  logic                wr_wins;
  logic                rd_gnt;
  logic                wr_gnt;

  ct_spsram_256x52_init_seq u_init_seq (
    .clk          (forever_cpuclk),
    .rst_n        (cpurst_b),
    .sweep_en_i   (in_init),
    .row_o        (init_row),
    .last_row_c_o (init_last_c),
    .done_o       (init_done_w)
  );

  // Next state, arbitration and SRAM drive; everything idles while in reset.
  always_comb begin
    state_d    = state_q;
    starve_d   = '0;
    in_init    = 1'b0;
    grant_en   = 1'b0;
    wr_wins    = 1'b0;
    rd_gnt     = 1'b0;
    wr_gnt     = 1'b0;
    sram_cen   = 1'b1;
    sram_gwen  = 1'b1;
    sram_wen   = '1;
    sram_a     = a_q;
    sram_d     = '0;
    if (!cpurst_b) begin
      sram_a = '0;
    end else begin
      case (state_q)
        INIT: begin
          in_init   = 1'b1;
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_a    = init_row;
          if (init_last_c) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // No grants until done is visible, so the release cycle stays idle.
          grant_en = init_done_w;
          wr_wins  = wr_req_vld &&
                     (!rd_req_vld || (starve_q == STARVE_W'(STARVE_MAX)));
          rd_gnt   = grant_en && rd_req_vld && !wr_wins;
          wr_gnt   = grant_en && wr_wins;
          // Count only cycles where a pending write lost to a read.
          if (wr_req_vld && rd_gnt) begin
            starve_d = starve_q + STARVE_W'(1);
          end
          if (rd_gnt) begin
            sram_cen = 1'b0;
            sram_a   = rd_req_idx;
          end else if (wr_gnt) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_a    = wr_req_idx;
            sram_d    = wr_req_data;
            sram_wen  = wen_from_bmask(wr_req_bmask);
          end
        end
        default: state_d = RST_STATE;
      endcase
    end
  end

  assign rd_req_rdy   = grant_en && !wr_wins;
  assign wr_req_rdy   = grant_en && wr_wins;
  assign rd_resp_vld  = rd_resp_vld_q;
  assign rd_resp_data = rd_resp_data_q;
  assign init_done    = init_done_w;

  // State, starvation count, held address and the read response pipeline.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state_q        <= RST_STATE;
      starve_q       <= '0;
      a_q            <= '0;
      rd_pend_q      <= 1'b0;
      rd_resp_vld_q  <= 1'b0;
      rd_resp_data_q <= '0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      a_q           <= sram_a;
      rd_pend_q     <= rd_gnt;
      rd_resp_vld_q <= rd_pend_q;
      if (rd_pend_q) begin
        rd_resp_data_q <= sram_q;
      end
    end
  end

endmodule

// File: tb/tb_ct_spsram_256x52_acc_ctrl.sv
`timescale 1ns/1ps
module tb_ct_spsram_256x52_acc_ctrl;

  localparam int DW = 52;
`ifdef CT_SPSRAM_ACC_INIT_EN
  localparam int DONE_CYC = 257;
`else
  localparam int DONE_CYC = 2;
`endif

  logic          clk;
  logic          cpurst_b;
  logic          wr_req_vld, wr_req_rdy, rd_req_vld, rd_req_rdy;
  logic [7:0]    wr_req_idx, rd_req_idx, sram_a;
  logic [DW-1:0] wr_req_data, rd_resp_data, sram_wen, sram_d, sram_q;
  logic [1:0]    wr_req_bmask;
  logic          rd_resp_vld, init_done, sram_cen, sram_gwen;

  ct_spsram_256x52_acc_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (cpurst_b),
    .wr_req_vld     (wr_req_vld),
    .wr_req_rdy     (wr_req_rdy),
    .wr_req_idx     (wr_req_idx),
    .wr_req_data    (wr_req_data),
    .wr_req_bmask   (wr_req_bmask),
    .rd_req_vld     (rd_req_vld),
    .rd_req_rdy     (rd_req_rdy),
    .rd_req_idx     (rd_req_idx),
    .rd_resp_vld    (rd_resp_vld),
    .rd_resp_data   (rd_resp_data),
    .init_done      (init_done),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM macro owned by the bench (starts all zero).
  logic [DW-1:0] mem [256];
  bit            mem_ready;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem_ready = 1'b1;
    end
    if (sram_cen === 1'b0) begin
      if (sram_gwen === 1'b0) mem[sram_a] = (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else sram_q <= mem[sram_a];
    end
  end

  // Reference model state.
  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } resp_t;

  logic [DW-1:0] ref_mem [256];
  resp_t         resp_q [$];
  int            cyc, starve, errors, checks;
  logic [7:0]    last_a;
  logic [DW-1:0] last_resp;
  bit            g_r, g_w;

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input bit rv, input logic [7:0] ri, input bit wv, input logic [7:0] wi,
                      input logic [DW-1:0] wd, input logic [1:0] bm, output bit rg, output bit wg);
    bit            run;
    logic [DW-1:0] m;
    resp_t         r;
    rd_req_vld = rv; rd_req_idx = ri;
    wr_req_vld = wv; wr_req_idx = wi; wr_req_data = wd; wr_req_bmask = bm;
    #3;
    run = (cyc >= DONE_CYC);
    rg = 1'b0; wg = 1'b0;
    if (run) begin
      if (wv && (!rv || starve == 3)) wg = 1'b1;
      else if (rv) rg = 1'b1;
    end
    checks++;
    if (init_done !== run) begin
      errors++; $display("FAIL init_done cyc=%0d got=%b exp=%b", cyc, init_done, run);
    end
    checks++;
    if ({rd_req_vld & rd_req_rdy, wr_req_vld & wr_req_rdy} !== {rg, wg}) begin
      errors++; $display("FAIL grant cyc=%0d got rd/wr=%b%b exp=%b%b", cyc,
                         rd_req_vld & rd_req_rdy, wr_req_vld & wr_req_rdy, rg, wg);
    end
    if (!run) begin
      checks++;
      if ({rd_req_rdy, wr_req_rdy} !== 2'b00) begin
        errors++; $display("FAIL rdy_not_ready cyc=%0d got=%b%b exp=00", cyc, rd_req_rdy, wr_req_rdy);
      end
    end
    checks++;
    if (wg) begin
      m = {{26{~bm[1]}}, {26{~bm[0]}}};
      if ({sram_cen, sram_gwen, sram_a, sram_wen, sram_d} !== {1'b0, 1'b0, wi, m, wd}) begin
        errors++; $display("FAIL sram_write cyc=%0d got cen=%b gwen=%b a=%h wen=%h d=%h exp a=%h wen=%h d=%h",
                           cyc, sram_cen, sram_gwen, sram_a, sram_wen, sram_d, wi, m, wd);
      end
      last_a = wi;
    end else if (rg) begin
      if ({sram_cen, sram_gwen, sram_a} !== {1'b0, 1'b1, ri}) begin
        errors++; $display("FAIL sram_read cyc=%0d got cen=%b gwen=%b a=%h exp a=%h",
                           cyc, sram_cen, sram_gwen, sram_a, ri);
      end
      last_a = ri;
`ifdef CT_SPSRAM_ACC_INIT_EN
    end else if (!run) begin
      if ({sram_cen, sram_gwen, sram_a, sram_wen, sram_d} !== {1'b0, 1'b0, 8'(cyc - 1), {DW{1'b0}}, {DW{1'b0}}}) begin
        errors++; $display("FAIL init_sweep cyc=%0d got cen=%b gwen=%b a=%h wen=%h d=%h exp a=%h",
                           cyc, sram_cen, sram_gwen, sram_a, sram_wen, sram_d, 8'(cyc - 1));
      end
      last_a = 8'(cyc - 1);
`endif
    end else begin
      if ({sram_cen, sram_gwen, sram_a} !== {1'b1, 1'b1, last_a}) begin
        errors++; $display("FAIL sram_idle cyc=%0d got cen=%b gwen=%b a=%h exp a=%h",
                           cyc, sram_cen, sram_gwen, sram_a, last_a);
      end
    end
    checks++;
    if (resp_q.size() != 0 && resp_q[0].due == cyc) begin
      if (rd_resp_vld !== 1'b1 || rd_resp_data !== resp_q[0].data) begin
        errors++; $display("FAIL rd_resp cyc=%0d got vld=%b data=%h exp vld=1 data=%h",
                           cyc, rd_resp_vld, rd_resp_data, resp_q[0].data);
      end
      last_resp = resp_q[0].data;
      void'(resp_q.pop_front());
    end else begin
      if (rd_resp_vld !== 1'b0 || rd_resp_data !== last_resp) begin
        errors++; $display("FAIL rd_resp_hold cyc=%0d got vld=%b data=%h exp vld=0 data=%h",
                           cyc, rd_resp_vld, rd_resp_data, last_resp);
      end
    end
    if (rg) begin
      r.due = cyc + 2; r.data = ref_mem[ri];
      resp_q.push_back(r);
    end
    if (wg) begin
      m = {{26{bm[1]}}, {26{bm[0]}}};
      ref_mem[wi] = (ref_mem[wi] & ~m) | (wd & m);
    end
    if (!run || !wv || wg) starve = 0;
    else if (rg) starve++;
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 8'h00, '0, 2'b00, g_r, g_w);
  endtask

  task automatic settle();
    while (cyc < DONE_CYC) idle(1);
  endtask

  task automatic do_reset(input int n);
    cpurst_b = 1'b0;
    rd_req_vld = 1'b1; rd_req_idx = 8'h33;
    wr_req_vld = 1'b1; wr_req_idx = 8'h44; wr_req_data = '1; wr_req_bmask = 2'b11;
    for (int i = 0; i < n; i++) begin
      #3;
      checks++;
      if ({rd_req_rdy, wr_req_rdy, sram_cen, sram_gwen, sram_a, sram_wen, sram_d} !==
          {1'b0, 1'b0, 1'b1, 1'b1, 8'h00, {DW{1'b1}}, {DW{1'b0}}}) begin
        errors++; $display("FAIL reset_drive got rdy=%b%b cen=%b gwen=%b a=%h wen=%h d=%h",
                           rd_req_rdy, wr_req_rdy, sram_cen, sram_gwen, sram_a, sram_wen, sram_d);
      end
      if (i > 0) begin
        checks++;
        if ({rd_resp_vld, rd_resp_data, init_done} !== {1'b0, {DW{1'b0}}, 1'b0}) begin
          errors++; $display("FAIL reset_regs got vld=%b data=%h done=%b exp 0/0/0",
                             rd_resp_vld, rd_resp_data, init_done);
        end
      end
      @(posedge clk); #1;
    end
    cpurst_b = 1'b1; rd_req_vld = 1'b0; wr_req_vld = 1'b0;
    cyc = 1; starve = 0; last_a = '0; last_resp = '0;
    resp_q.delete();
`ifdef CT_SPSRAM_ACC_INIT_EN
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
`endif
  endtask

  task automatic test_reset();
    do_reset(3);
    settle();
  endtask

  task automatic test_write_read();
    step(1'b0, 8'h00, 1'b1, 8'h12, 52'hABCDE1234567, 2'b11, g_r, g_w);
    step(1'b1, 8'h12, 1'b0, 8'h00, '0, 2'b00, g_r, g_w);
    idle(3);
  endtask

  task automatic test_bmask();
    step(1'b0, 8'h00, 1'b1, 8'h05, {DW{1'b1}}, 2'b01, g_r, g_w);
    step(1'b1, 8'h05, 1'b0, 8'h00, '0, 2'b00, g_r, g_w);
    step(1'b0, 8'h00, 1'b1, 8'h12, 52'h123456789ABCD, 2'b00, g_r, g_w);
    step(1'b1, 8'h12, 1'b0, 8'h00, '0, 2'b00, g_r, g_w);
    idle(3);
  endtask

  task automatic test_starvation();
    logic [7:0] pat;
    idle(1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 8'(8'h80 + i), 52'($urandom), 2'b11, g_r, g_w);
      pat[i] = g_w;
    end
    idle(3);
    checks++;
    if (pat !== 8'b1000_1000) begin
      errors++; $display("FAIL starvation_pattern got=%b exp=10001000", pat);
    end
  endtask

  task automatic test_collision();
    bit rg, wg;
    step(1'b0, 8'h00, 1'b1, 8'h40, 52'h1, 2'b11, g_r, g_w);
    idle(1);
    step(1'b1, 8'h40, 1'b1, 8'h40, 52'h2, 2'b11, rg, wg);
    checks++;
    if ({rd_resp_vld, rg, wg} !== 3'b010) begin
      errors++; $display("FAIL collision_grant got rg=%b wg=%b exp rg=1 wg=0", rg, wg);
    end
    step(1'b0, 8'h00, 1'b1, 8'h40, 52'h2, 2'b11, g_r, g_w);
    step(1'b1, 8'h40, 1'b0, 8'h00, '0, 2'b00, g_r, g_w);
    idle(3);
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0, 8'h00, '0, 2'b00, g_r, g_w);
      if (g_r) n++;
    end
    idle(3);
    checks++;
    if (resp_q.size() != 0) begin
      errors++; $display("FAIL b2b_drain got pending=%0d exp=0", resp_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)),
           52'({$urandom, $urandom}), 2'($urandom_range(0, 3)), g_r, g_w);
    end
    idle(3);
    checks++;
    if (resp_q.size() != 0) begin
      errors++; $display("FAIL random_drain got pending=%0d exp=0", resp_q.size());
    end
  endtask

  task automatic test_reset_midread();
    step(1'b1, 8'h12, 1'b0, 8'h00, '0, 2'b00, g_r, g_w);
    do_reset(2);
    settle();
    idle(4);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0; checks = 0; cyc = 0; starve = 0;
    last_a = '0; last_resp = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    cpurst_b = 1'b0;
    rd_req_vld = 1'b0; rd_req_idx = '0;
    wr_req_vld = 1'b0; wr_req_idx = '0; wr_req_data = '0; wr_req_bmask = '0;
    @(posedge clk); #1;
    test_reset();
    test_write_read();
    test_bmask();
    test_starvation();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_midread();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
